// File: rtl/data_sync_tx_if.sv
// Handshake and launch-bus bundle between a word producer and data_sync_tx.
// The master side is the producer (and observer of the launch bus);
// the slave side is data_sync_tx itself.
interface data_sync_tx_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] unsync_bus;
   logic                  bus_enable;
   logic                  tx_done;
   logic                  busy;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  unsync_bus,
      input  bus_enable,
      input  tx_done,
      input  busy
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output unsync_bus,
      output bus_enable,
      output tx_done,
      output busy
   );

endinterface

// File: rtl/data_sync_tx.sv
// Source-domain launcher for a multi-bit data synchronizer.
// A word accepted on the valid/ready handshake is placed on a registered bus
// together with a one-cycle enable pulse, then the bus is frozen for
// HOLD_CYCLES cycles so the destination enable synchronizer (NUM_STAGES flops)
// can see the pulse and capture the bus while it is guaranteed stable.
module data_sync_tx #(
   parameter int NUM_STAGES  = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int HOLD_CYCLES = NUM_STAGES + 2
) (
   input logic           clk,
   input logic           rst_n,
   data_sync_tx_if.slave bus
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] unsync_bus_q;
   logic                  bus_enable_q;
   logic                  tx_done_q;

   // Launch FSM: every bus-facing output is a flop so the destination domain
   // only ever sees clean, glitch-free transitions; the bus is only loaded on
   // the edge entering LAUNCH and is frozen for the whole hold window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         unsync_bus_q <= '0;
         bus_enable_q <= 1'b0;
         tx_done_q    <= 1'b0;
      end else begin
         bus_enable_q <= 1'b0;
         tx_done_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  unsync_bus_q <= bus.in_data;
                  bus_enable_q <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= CNT_W'(HOLD_CYCLES - 1);
               state <= HOLD;
            end
            HOLD: begin
               if (cnt == '0) begin
                  tx_done_q <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status decoded straight from the state register; in_ready is also gated
   // by reset so nothing is offered as accepted while reset is asserted.
   always_comb begin
      bus.busy     = (state != IDLE);
      bus.in_ready = (state == IDLE) && rst_n;
   end

   // Registered outputs onto the bundle.
   always_comb begin
      bus.unsync_bus = unsync_bus_q;
      bus.bus_enable = bus_enable_q;
      bus.tx_done    = tx_done_q;
   end

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed testbench for data_sync_tx with default parameters
// (NUM_STAGES=2, DATA_WIDTH=8, HOLD_CYCLES=4), including a small
// destination-side synchronizer on an unrelated faster clock for loopback.
module tb_data_sync_tx;

   logic clk;
   logic rst_n;
   logic dst_clk;

   int n_checks;
   int n_fail;

   data_sync_tx_if #(.DATA_WIDTH(8)) tx_bus ();

   data_sync_tx #(
      .NUM_STAGES (2),
      .DATA_WIDTH (8),
      .HOLD_CYCLES(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (tx_bus.slave)
   );

   // Destination-domain model: two-flop enable synchronizer, rising-edge
   // detect, and a capture register plus a pulse counter.
   logic [1:0] en_sync;
   logic       en_prev;
   logic       enable_pulse;
   logic [7:0] sync_bus;
   int         pulse_cnt;

   assign enable_pulse = en_sync[1] & ~en_prev;

   // Source clock 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Destination clock 6 ns period, unrelated phase.
   initial begin
      dst_clk = 1'b0;
      #2;
      forever #3 dst_clk = ~dst_clk;
   end

   // Destination synchronizer flops, captured bus and pulse count.
   always_ff @(posedge dst_clk or negedge rst_n) begin
      if (!rst_n) begin
         en_sync   <= 2'b00;
         en_prev   <= 1'b0;
         sync_bus  <= 8'h00;
         pulse_cnt <= 0;
      end else begin
         en_sync <= {en_sync[0], tx_bus.bus_enable};
         en_prev <= en_sync[1];
         if (enable_pulse) begin
            sync_bus  <= tx_bus.unsync_bus;
            pulse_cnt <= pulse_cnt + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data);
      tx_bus.in_valid = valid;
      tx_bus.in_data  = data;
   endtask

   // Check all launcher outputs at once.
   task automatic checkAll(input string tag, input logic [7:0] exp_bus,
                           input logic exp_en, input logic exp_done,
                           input logic exp_ready, input logic exp_busy);
      checkOutput({tag, ".unsync_bus"}, 32'(tx_bus.unsync_bus), 32'(exp_bus));
      checkOutput({tag, ".bus_enable"}, 32'(tx_bus.bus_enable), 32'(exp_en));
      checkOutput({tag, ".tx_done"},    32'(tx_bus.tx_done),    32'(exp_done));
      checkOutput({tag, ".in_ready"},   32'(tx_bus.in_ready),   32'(exp_ready));
      checkOutput({tag, ".busy"},       32'(tx_bus.busy),       32'(exp_busy));
   endtask

   // Full single-transfer timing of one word with HOLD_CYCLES=4.
   task automatic singleTransfer(input string tag, input logic [7:0] word);
      applyStimulus(1'b1, word);
      step();
      applyStimulus(1'b0, 8'h00);
      checkAll({tag, ".launch"}, word, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkAll($sformatf("%s.hold%0d", tag, i), word, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step();
      checkAll({tag, ".done"}, word, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      checkAll({tag, ".idle"}, word, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Directed test sequence.
   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held for two cycles with an active producer.
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'hFF);
      #1;
      checkAll("reset0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkAll("reset1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkAll("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00);
      rst_n = 1'b1;
      #1;
      checkAll("reset_release", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkAll("idle_no_valid", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Single transfer.
      $display("[TB] single transfer");
      singleTransfer("single", 8'h2D);

      // Back-to-back with in_valid held high: pulses six cycles apart.
      $display("[TB] back-to-back");
      applyStimulus(1'b1, 8'hDB);
      step();
      checkAll("b2b.first_launch", 8'hDB, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h5A);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkAll($sformatf("b2b.hold%0d", i), 8'hDB, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step();
      checkAll("b2b.done", 8'hDB, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      checkAll("b2b.second_launch", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkAll($sformatf("b2b.hold2_%0d", i), 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step();
      checkAll("b2b.done2", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
      step();

      // Producer activity while busy must be ignored.
      $display("[TB] ignored input while busy");
      applyStimulus(1'b1, 8'h33);
      step();
      checkAll("ign.launch", 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(i[0], 8'(8'h40 + i));
         step();
         checkAll($sformatf("ign.hold%0d", i), 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      applyStimulus(1'b1, 8'h77);
      step();
      checkAll("ign.done", 8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00);
      step();
      checkAll("ign.idle", 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);

      // Abort in the second HOLD cycle of 8'hA5.
      $display("[TB] abort mid-hold");
      applyStimulus(1'b1, 8'hA5);
      step();
      applyStimulus(1'b0, 8'h00);
      checkAll("abort.launch", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      step();
      checkAll("abort.hold2", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAll("abort.async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkAll("abort.held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checkAll($sformatf("abort.after%0d", i), 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Loopback through the destination synchronizer after the abort.
      $display("[TB] loopback");
      singleTransfer("loop1", 8'h2D);
      checkOutput("loop1.sync_bus", 32'(sync_bus), 32'h2D);
      checkOutput("loop1.pulses", 32'(pulse_cnt), 32'd1);
      singleTransfer("loop2", 8'hDB);
      checkOutput("loop2.sync_bus", 32'(sync_bus), 32'hDB);
      checkOutput("loop2.pulses", 32'(pulse_cnt), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sync_tx.md
# data_sync_tx

Source-domain launcher for a multi-bit data synchronizer. Accepts words through a valid/ready handshake. Each accepted word is driven onto a registered, glitch-free bus with a one-cycle enable pulse. The bus is then held stable long enough for the destination-side synchronizer, which has NUM_STAGES flops on the enable path, to sample it safely. The block sits in the transmitting clock domain and directly drives the destination synchronizer's unsync_bus/bus_enable inputs.

## Interface
- NUM_STAGES, 2, number of enable-synchronizer stages in the destination block
- DATA_WIDTH, 8, width of the transferred word
- HOLD_CYCLES, NUM_STAGES+2, cycles the bus is held after the enable pulse; legal range 1..255

- CLK  input  1  source-domain clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- in_data  input  DATA_WIDTH  word to transfer; sampled when in_valid && in_ready
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word (state IDLE, RST high)
- unsync_bus  output  DATA_WIDTH  registered data toward destination domain
- bus_enable  output  1  registered one-cycle launch pulse toward destination domain
- tx_done  output  1  registered one-cycle pulse when the hold window ends
- busy  output  1  high in LAUNCH or HOLD

## Operation
- FSM states: IDLE, LAUNCH, HOLD. Hold counter width is clog2(HOLD_CYCLES+1).
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: unsync_bus<=in_data, bus_enable<=1, state<=LAUNCH.
  - With in_valid=0: no change.
- LAUNCH (exactly one cycle): bus_enable<=0, cnt<=HOLD_CYCLES-1, state<=HOLD.
- HOLD:
  - unsync_bus frozen; in_data and in_valid ignored.
  - If cnt==0: state<=IDLE and tx_done<=1.
  - Otherwise cnt<=cnt-1.
- tx_done is 0 in every other cycle.
- unsync_bus keeps the last launched word in IDLE; it is never cleared except by reset.
- unsync_bus changes only on the edge that enters LAUNCH. It never changes while bus_enable=1 or in HOLD.
- bus_enable is never high in two consecutive cycles.
- busy = (state != IDLE). in_ready = (state == IDLE) && RST.
- Reset values, applied asynchronously on RST low:
  - Registered: state IDLE, unsync_bus 0, bus_enable 0, tx_done 0, cnt 0.
  - Combinational: busy 0, in_ready 0 while RST is low.
- Reset mid-transfer (LAUNCH or HOLD) aborts immediately: bus goes to 0 and the word is dropped. No tx_done is produced for it.
- HOLD_CYCLES=1: HOLD lasts one cycle, with cnt loaded to 0.

## Timing
- Handshake accepted at edge k. Then:
  - bus_enable=1 and unsync_bus=word during cycle k..k+1.
  - HOLD occupies HOLD_CYCLES cycles, edges k+1..k+1+HOLD_CYCLES.
  - tx_done=1 for one cycle after edge k+1+HOLD_CYCLES; in_ready is 1 in that same cycle.
- Latency from acceptance to bus_enable: 1 cycle.
- Back-to-back throughput: one word per HOLD_CYCLES+2 cycles. Defaults: bus_enable pulses 6 cycles apart with in_valid held high.
- A word accepted in the tx_done cycle is legal; its bus_enable rises on the next edge.
- in_valid high outside IDLE does not consume data. The producer must hold in_data until in_ready.
- All outputs are registered except in_ready and busy, which are decoded from the state register.

## Test plan
- Reset:
  - Stimulus: RST low for 2 cycles with in_valid=1, in_data=8'hFF.
  - Required: unsync_bus=0, bus_enable=0, tx_done=0, in_ready=0 throughout. After release, in_ready=1.
- Single transfer:
  - Stimulus: in_data=8'h2D, one-cycle in_valid.
  - Required: next cycle bus_enable=1, unsync_bus=8'h2D. bus_enable low afterwards; bus stable for 4 HOLD cycles; tx_done pulses once; busy high for 5 cycles.
- Back-to-back:
  - Stimulus: in_valid held high, in_data=8'hDB then 8'h5A.
  - Required: bus_enable pulses exactly 6 cycles apart. unsync_bus=8'hDB up to the second pulse, then 8'h5A. No change during HOLD.
- Ignored input during HOLD:
  - Stimulus: toggle in_data and in_valid while busy.
  - Required: unsync_bus unchanged, no extra bus_enable, in_ready=0.
- Abort:
  - Stimulus: assert RST low in the second HOLD cycle of word 8'hA5.
  - Required: outputs go to 0 asynchronously with no tx_done. The next transfer after release behaves as the single-transfer case.
- Loopback:
  - Stimulus: drive the destination synchronizer (NUM_STAGES=2) from this block and send 8'h2D then 8'hDB.
  - Required: the destination's sync_bus equals each word and its enable_pulse fires once per word.
